// File: rtl/sram_pkg.sv
// Shared types and default timing for the SRAM array controller.
package sram_pkg;

  localparam int unsigned DEF_ROWS    = 8;
  localparam int unsigned DEF_COLS    = 8;
  localparam int unsigned DEF_PRE_CYC = 2;
  localparam int unsigned DEF_WR_CYC  = 2;
  localparam int unsigned DEF_SA_CYC  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StPrecharge,
    StAccess,
    StRecover
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_row_dec.sv
// Row address to one-hot wordline decode; out-of-range addresses select nothing.
module sram_row_dec #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned ADDR_W = $clog2(ROWS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ROWS-1:0]   wl,
  output logic              oob
);

  always_comb begin
    wl = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      wl[i] = (32'(addr) == i);
    end
    oob = (32'(addr) >= ROWS);
  end

endmodule

// File: rtl/sram_ctrl.sv
// SRAM array sequencer: precharge, wordline access (write drive or sense), recover.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned ADDR_W  = $clog2(ROWS),
  parameter int unsigned PRE_CYC = DEF_PRE_CYC,
  parameter int unsigned WR_CYC  = DEF_WR_CYC,
  parameter int unsigned SA_CYC  = DEF_SA_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_wdata,
  output logic              pre_en,
  output logic [ROWS-1:0]   wl_en,
  output logic              wd_en,
  output logic [COLS-1:0]   wd_data,
  output logic              sa_en,
  input  logic [COLS-1:0]   sa_out,
  output logic              rd_valid,
  output logic [COLS-1:0]   rd_data,
  output logic              err
);

  localparam int unsigned MAX_CYC = max3(PRE_CYC, WR_CYC, SA_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [COLS-1:0]     wd_data_q, rd_data_q;
  logic [ROWS-1:0]     dec_wl;
  logic                dec_oob;
  logic                accept;
  logic                last;

  sram_row_dec #(
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) u_row_dec (
    .addr(addr_q),
    .wl  (dec_wl),
    .oob (dec_oob)
  );

  assign accept = req_valid && (state_q == StIdle);
  // Counter is loaded with duration-1 on phase entry and counts down to zero.
  assign last   = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    pre_en    = 1'b0;
    wl_en     = '0;
    wd_en     = 1'b0;
    sa_en     = 1'b0;
    rd_valid  = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = StPrecharge;
          cnt_d   = CNT_W'(PRE_CYC - 1);
        end
      end
      StPrecharge: begin
        pre_en = 1'b1;
        if (last) begin
          state_d = StAccess;
          cnt_d   = we_q ? CNT_W'(WR_CYC - 1) : CNT_W'(SA_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StAccess: begin
        wl_en = dec_wl;
        wd_en = we_q;
        sa_en = !we_q && last;
        if (last) begin
          state_d = StRecover;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRecover: begin
        rd_valid = !we_q && !dec_oob;
        err      = dec_oob;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= req_we;
        addr_q <= req_addr;
        if (req_we) begin
          wd_data_q <= req_wdata;
        end
      end
      if ((state_q == StAccess) && !we_q && last) begin
        rd_data_q <= sa_out;
      end
    end
  end

  assign wd_data = wd_data_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default build plus a ROWS=6 build for range checks.
module tb_sram_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       pre_en, wd_en, sa_en, rd_valid, err;
  logic [7:0] wl_en, wd_data, sa_out, rd_data;

  logic       req_valid6, req_ready6, req_we6;
  logic [2:0] req_addr6;
  logic [7:0] req_wdata6;
  logic       pre_en6, wd_en6, sa_en6, rd_valid6, err6;
  logic [5:0] wl_en6;
  logic [7:0] wd_data6, sa_out6, rd_data6;

  int n_checks = 0;
  int n_fail   = 0;

  sram_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .pre_en   (pre_en),
    .wl_en    (wl_en),
    .wd_en    (wd_en),
    .wd_data  (wd_data),
    .sa_en    (sa_en),
    .sa_out   (sa_out),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .err      (err)
  );

  sram_ctrl #(
    .ROWS(6)
  ) u_dut6 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid6),
    .req_ready(req_ready6),
    .req_we   (req_we6),
    .req_addr (req_addr6),
    .req_wdata(req_wdata6),
    .pre_en   (pre_en6),
    .wl_en    (wl_en6),
    .wd_en    (wd_en6),
    .wd_data  (wd_data6),
    .sa_en    (sa_en6),
    .sa_out   (sa_out6),
    .rd_valid (rd_valid6),
    .rd_data  (rd_data6),
    .err      (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_phase(input string tag, input logic pre, input logic [7:0] wl,
                           input logic wd, input logic sa, input logic rv, input logic rdy);
    chk({tag, ".pre_en"}, {31'd0, pre_en}, {31'd0, pre});
    chk({tag, ".wl_en"}, {24'd0, wl_en}, {24'd0, wl});
    chk({tag, ".wd_en"}, {31'd0, wd_en}, {31'd0, wd});
    chk({tag, ".sa_en"}, {31'd0, sa_en}, {31'd0, sa});
    chk({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, rv});
    chk({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, rdy});
  endtask

  // Present a request for one edge, then scramble the request bus.
  task automatic issue(input logic we, input logic [2:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    step();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~data;
  endtask

  initial begin
    int ovl;
    int wdsa;
    int bad;
    int wl6;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sa_out = '0;
    req_valid6 = 1'b0; req_we6 = 1'b0; req_addr6 = '0; req_wdata6 = '0; sa_out6 = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wl_en_during", {24'd0, wl_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Reset state
    chk_phase("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.wd_data", {24'd0, wd_data}, 32'd0);
    chk("reset.rd_data", {24'd0, rd_data}, 32'd0);
    chk("reset.err", {31'd0, err}, 32'd0);

    // Write addr 3, data 0xA5
    issue(1'b1, 3'd3, 8'hA5);
    chk_phase("wr.c1", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_phase("wr.c2", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_phase("wr.c3", 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr.c3.wd_data", {24'd0, wd_data}, 32'hA5);
    step();
    chk_phase("wr.c4", 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr.c4.wd_data", {24'd0, wd_data}, 32'hA5);
    step();
    chk_phase("wr.c5", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wr.c5.err", {31'd0, err}, 32'd0);
    step();
    chk_phase("wr.c6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Read addr 5; sa_out is only 0x3C during the strobe cycle
    sa_out = 8'h11;
    issue(1'b0, 3'd5, 8'h00);
    chk_phase("rd.c1", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_phase("rd.c2", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_phase("rd.c3", 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_phase("rd.c4", 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_phase("rd.c5", 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    sa_out = 8'h3C;
    step();
    sa_out = 8'h77;
    chk_phase("rd.c6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rd.c6.rd_data", {24'd0, rd_data}, 32'h3C);
    chk("rd.c6.err", {31'd0, err}, 32'd0);
    step();
    chk_phase("rd.c7", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rd.c7.rd_data", {24'd0, rd_data}, 32'h3C);
    chk("rd.c7.wd_data", {24'd0, wd_data}, 32'hA5);

    // req_valid held high: write addr 1 then read addr 2 back to back
    ovl = 0;
    wdsa = 0;
    sa_out = 8'hC3;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'h5A;
    step();
    req_we = 1'b0; req_addr = 3'd2; req_wdata = 8'hFF;
    for (int c = 1; c <= 13; c++) begin
      if (pre_en && (wl_en != 8'h00)) ovl++;
      if (wd_en && sa_en) wdsa++;
      if (c == 3) begin
        chk("b2b.c3.wl_en", {24'd0, wl_en}, 32'h02);
        chk("b2b.c3.wd_data", {24'd0, wd_data}, 32'h5A);
      end
      if (c == 5) chk("b2b.c5.req_ready", {31'd0, req_ready}, 32'd0);
      if (c == 6) chk("b2b.c6.req_ready", {31'd0, req_ready}, 32'd1);
      if (c == 7) begin
        chk("b2b.c7.pre_en", {31'd0, pre_en}, 32'd1);
        req_valid = 1'b0;
      end
      if (c == 9) chk("b2b.c9.wl_en", {24'd0, wl_en}, 32'h04);
      if (c == 12) begin
        chk("b2b.c12.rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("b2b.c12.rd_data", {24'd0, rd_data}, 32'hC3);
      end
      if (c == 13) chk("b2b.c13.req_ready", {31'd0, req_ready}, 32'd1);
      if (c < 13) step();
    end
    chk("b2b.pre_wl_overlap", ovl, 0);
    chk("b2b.wd_sa_overlap", wdsa, 0);

    // Asynchronous reset in the middle of a write access
    issue(1'b1, 3'd3, 8'h0F);
    step();
    step();
    chk("rstmid.c3.wl_en", {24'd0, wl_en}, 32'h08);
    chk("rstmid.c3.wd_en", {31'd0, wd_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid.wl_en", {24'd0, wl_en}, 32'd0);
    chk("rstmid.wd_en", {31'd0, wd_en}, 32'd0);
    chk("rstmid.wd_data", {24'd0, wd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rd_valid || err || pre_en) bad++;
    end
    chk("rstmid.no_pulse", bad, 0);
    chk("rstmid.req_ready", {31'd0, req_ready}, 32'd1);

    // ROWS=6 instance: read of address 7 is out of range
    wl6 = 0;
    req_valid6 = 1'b1; req_we6 = 1'b0; req_addr6 = 3'd7;
    step();
    req_valid6 = 1'b0; req_addr6 = 3'd1;
    for (int c = 1; c <= 7; c++) begin
      if (wl_en6 != 6'd0) wl6++;
      chk($sformatf("oob.c%0d.err", c), {31'd0, err6}, (c == 6) ? 32'd1 : 32'd0);
      chk($sformatf("oob.c%0d.rd_valid", c), {31'd0, rd_valid6}, 32'd0);
      if (c == 7) chk("oob.c7.req_ready", {31'd0, req_ready6}, 32'd1);
      if (c < 7) step();
    end
    chk("oob.wl_en_zero", wl6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
